// File: rtl/data_former_mc.sv
// data_former_mc: multi-channel event counter with snapshot FIFO.
//
// Each channel keeps its own event counter. A start_send request walks
// every channel in turn. Each channel's count is pushed into the FIFO with
// its channel tag, and that counter is cleared as it is captured. Words
// leave on a valid/ready stream.
//
// Ports:
//   clk         rising-edge clock
//   a_rst_n     asynchronous reset, active low
//   s_rst       synchronous clear, active high (wins over everything else)
//   next_count  per-channel increment strobe
//   start_send  snapshot request (ignored while a snapshot is running)
//   ready       downstream ready; a word is popped on valid && ready
//   valid       FIFO head word valid
//   data        FIFO head count value
//   chan        FIFO head channel index
//   busy        snapshot in progress
//   fifo_level  words held after the last edge
//   overflow    sticky: some counter incremented past all-ones
//
// FSM states:
//   state    | meaning
//   ---------+------------------------------------------------
//   st_idle  | waiting for start_send
//   st_dump  | pushing channel idx_q into the FIFO when space allows
module data_former_mc #(
    parameter int p_data_width = 8,
    parameter int p_channels   = 4,
    parameter int p_depth      = 4,
    parameter bit p_saturate   = 1'b1,
    localparam int c_chan_w    = (p_channels > 1) ? $clog2(p_channels) : 1,
    localparam int c_lvl_w     = $clog2(p_depth + 1)
) (
    input  logic                    clk,
    input  logic                    a_rst_n,
    input  logic                    s_rst,
    input  logic [p_channels-1:0]   next_count,
    input  logic                    start_send,
    input  logic                    ready,
    output logic                    valid,
    output logic [p_data_width-1:0] data,
    output logic [c_chan_w-1:0]     chan,
    output logic                    busy,
    output logic [c_lvl_w-1:0]      fifo_level,
    output logic                    overflow
);

    localparam int c_ptr_w = $clog2(p_depth);

    typedef enum logic {st_idle, st_dump} state_t;

    state_t                  state_q, state_d;
    logic [c_chan_w-1:0]     idx_q, idx_d;
    logic [p_data_width-1:0] cnt_q [p_channels];
    logic [p_data_width-1:0] cnt_d [p_channels];
    logic [p_data_width-1:0] mem_data_q [p_depth];
    logic [p_data_width-1:0] mem_data_d [p_depth];
    logic [c_chan_w-1:0]     mem_chan_q [p_depth];
    logic [c_chan_w-1:0]     mem_chan_d [p_depth];
    logic [c_ptr_w-1:0]      wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]      rd_ptr_q, rd_ptr_d;
    logic [c_lvl_w-1:0]      level_q, level_d;
    logic                    overflow_q, overflow_d;
    logic                    pop;
    logic                    push;

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        mem_data_d = mem_data_q;
        mem_chan_d = mem_chan_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;

        pop  = (level_q != '0) && ready;
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push = (state_q == st_dump) && ((level_q != c_lvl_w'(p_depth)) || pop);

        for (int i = 0; i < p_channels; i++) begin
            if (push && (idx_q == c_chan_w'(i))) begin
                // The coincident event is kept for the next snapshot.
                cnt_d[i] = next_count[i] ? p_data_width'(1) : '0;
            end else if (next_count[i]) begin
                if (cnt_q[i] == '1) begin
                    overflow_d = 1'b1;
                    cnt_d[i]   = p_saturate ? cnt_q[i] : '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + p_data_width'(1);
                end
            end
        end

        if (push) begin
            mem_data_d[wr_ptr_q] = cnt_q[idx_q];
            mem_chan_d[wr_ptr_q] = idx_q;
            wr_ptr_d = (wr_ptr_q == c_ptr_w'(p_depth - 1)) ? '0 : wr_ptr_q + c_ptr_w'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == c_ptr_w'(p_depth - 1)) ? '0 : rd_ptr_q + c_ptr_w'(1);
        end

        case ({push, pop})
            2'b10:   level_d = level_q + c_lvl_w'(1);
            2'b01:   level_d = level_q - c_lvl_w'(1);
            default: level_d = level_q;
        endcase

        case (state_q)
            st_idle: begin
                if (start_send) begin
                    state_d = st_dump;
                    idx_d   = '0;
                end
            end
            st_dump: begin
                if (push) begin
                    if (idx_q == c_chan_w'(p_channels - 1)) begin
                        state_d = st_idle;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + c_chan_w'(1);
                    end
                end
            end
            default: state_d = st_idle;
        endcase

        if (s_rst) begin
            state_d    = st_idle;
            idx_d      = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            level_d    = '0;
            overflow_d = 1'b0;
            for (int i = 0; i < p_channels; i++) cnt_d[i] = '0;
            // Storage is cleared too so the head never shows stale data after a clear.
            for (int i = 0; i < p_depth; i++) begin
                mem_data_d[i] = '0;
                mem_chan_d[i] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n) begin
            state_q    <= st_idle;
            idx_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < p_channels; i++) cnt_q[i] <= '0;
            for (int i = 0; i < p_depth; i++) begin
                mem_data_q[i] <= '0;
                mem_chan_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
            cnt_q      <= cnt_d;
            mem_data_q <= mem_data_d;
            mem_chan_q <= mem_chan_d;
        end
    end

    assign valid      = (level_q != '0);
    assign data       = mem_data_q[rd_ptr_q];
    assign chan       = mem_chan_q[rd_ptr_q];
    assign busy       = (state_q == st_dump);
    assign fifo_level = level_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_data_former_mc.sv
// Testbench for data_former_mc: a cycle-level reference model predicts every
// FIFO word into a scoreboard queue; a negedge monitor compares the DUT head
// and status against the model. A second instance with wrapping counters
// covers the non-saturating overflow case.
module tb_data_former_mc;

    localparam int W    = 8;
    localparam int C    = 4;
    localparam int D    = 4;
    localparam int CW   = 2;
    localparam int LW   = 3;
    localparam int MAXV = 255;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          a_rst_n = 1'b0;
    logic          s_rst = 1'b0, start_send = 1'b0, ready = 1'b0;
    logic [C-1:0]  next_count = '0;
    logic          valid, busy, overflow;
    logic [W-1:0]  data;
    logic [CW-1:0] chan;
    logic [LW-1:0] fifo_level;

    logic          s_rst_w = 1'b0, start_w = 1'b0, ready_w = 1'b0;
    logic [C-1:0]  nc_w = '0;
    logic          valid_w, busy_w, overflow_w;
    logic [W-1:0]  data_w;
    logic [CW-1:0] chan_w;
    logic [LW-1:0] level_w;

    data_former_mc #(.p_data_width(W), .p_channels(C), .p_depth(D), .p_saturate(1'b1)) dut (
        .clk(clk), .a_rst_n(a_rst_n), .s_rst(s_rst), .next_count(next_count),
        .start_send(start_send), .ready(ready), .valid(valid), .data(data),
        .chan(chan), .busy(busy), .fifo_level(fifo_level), .overflow(overflow));

    data_former_mc #(.p_data_width(W), .p_channels(C), .p_depth(D), .p_saturate(1'b0)) dut_w (
        .clk(clk), .a_rst_n(a_rst_n), .s_rst(s_rst_w), .next_count(nc_w),
        .start_send(start_w), .ready(ready_w), .valid(valid_w), .data(data_w),
        .chan(chan_w), .busy(busy_w), .fifo_level(level_w), .overflow(overflow_w));

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: counts as plain integers, FIFO occupancy as a number.
    int          mcnt [C];
    int          mlevel = 0;
    bit          mdump = 1'b0;
    int          midx = 0;
    bit          movf = 1'b0;
    bit          m_pop, m_push;
    logic [15:0] exp_q[$];
    logic [15:0] rx_log[$];
    int          busy_cnt = 0;

    task automatic model_clear();
        for (int i = 0; i < C; i++) mcnt[i] = 0;
        mlevel = 0;
        mdump  = 1'b0;
        midx   = 0;
        movf   = 1'b0;
        exp_q.delete();
    endtask

    always @(posedge clk or negedge a_rst_n) begin
        if (!a_rst_n || s_rst) begin
            model_clear();
        end else begin
            m_pop  = (mlevel > 0) && ready;
            m_push = mdump && ((mlevel < D) || m_pop);
            for (int i = 0; i < C; i++) begin
                if (m_push && i == midx) begin
                    exp_q.push_back({8'(midx), 8'(mcnt[i])});
                    mcnt[i] = next_count[i] ? 1 : 0;
                end else if (next_count[i]) begin
                    mcnt[i] = mcnt[i] + 1;
                    if (mcnt[i] > MAXV) begin
                        movf    = 1'b1;
                        mcnt[i] = MAXV;
                    end
                end
            end
            mlevel = mlevel + int'(m_push) - int'(m_pop);
            if (mdump) begin
                if (m_push) begin
                    if (midx == C - 1) mdump = 1'b0;
                    else midx++;
                end
            end else if (start_send) begin
                mdump = 1'b1;
                midx  = 0;
            end
        end
    end

    // Monitor: status every cycle, head word whenever valid, pop on valid&&ready.
    always @(negedge clk) begin
        chk("valid", valid, mlevel > 0);
        chk("fifo_level", fifo_level, mlevel);
        chk("busy", busy, mdump);
        chk("overflow", overflow, movf);
        if (busy === 1'b1) busy_cnt++;
        if (valid === 1'b1) begin
            chk("sb_nonempty", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                chk("head_chan", chan, exp_q[0][15:8]);
                chk("head_data", data, exp_q[0][7:0]);
                if (ready && a_rst_n && !s_rst) begin
                    void'(exp_q.pop_front());
                    rx_log.push_back({8'(chan), data});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input string name);
        bit done = 1'b0;
        for (int k = 0; k < 300 && !done; k++) begin
            tick();
            if (!busy && fifo_level == 0) done = 1'b1;
        end
        chk(name, done, 1);
    endtask

    task automatic pulse_srst();
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
    endtask

    logic [15:0] basic_exp [4];
    logic [W-1:0] got_w;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        basic_exp[0] = {8'd0, 8'd3};
        basic_exp[1] = {8'd1, 8'd5};
        basic_exp[2] = {8'd2, 8'd0};
        basic_exp[3] = {8'd3, 8'd255};

        // Reset held with random inputs.
        for (int k = 0; k < 6; k++) begin
            next_count = C'($urandom);
            start_send = 1'($urandom);
            ready      = 1'($urandom);
            s_rst      = 1'($urandom);
            tick();
            chk("rst_valid", valid, 0);
            chk("rst_data", data, 0);
            chk("rst_chan", chan, 0);
            chk("rst_busy", busy, 0);
            chk("rst_level", fifo_level, 0);
            chk("rst_ovf", overflow, 0);
        end
        next_count = '0; start_send = 1'b0; ready = 1'b0; s_rst = 1'b0;
        a_rst_n = 1'b1;
        repeat (4) tick();
        chk("idle_valid", valid, 0);
        chk("idle_data", data, 0);
        chk("idle_chan", chan, 0);
        chk("idle_level", fifo_level, 0);

        // Basic dump: 3,5,0,255 events.
        ready = 1'b1;
        for (int k = 0; k < 255; k++) begin
            next_count = {1'b1, 1'b0, (k < 5), (k < 3)};
            tick();
        end
        next_count = '0;
        rx_log.delete();
        busy_cnt = 0;
        start_send = 1'b1;
        tick();
        start_send = 1'b0;
        wait_drain("basic_drain");
        chk("basic_busy_cycles", busy_cnt, 4);
        chk("basic_words", rx_log.size(), 4);
        for (int k = 0; k < 4 && k < rx_log.size(); k++) chk("basic_word", rx_log[k], basic_exp[k]);
        rx_log.delete();
        start_send = 1'b1;
        tick();
        start_send = 1'b0;
        wait_drain("zero_drain");
        chk("zero_words", rx_log.size(), 4);
        for (int k = 0; k < rx_log.size(); k++) chk("zero_data", rx_log[k][7:0], 0);

        // Backpressure: two dumps ten cycles apart with ready low.
        pulse_srst();
        ready = 1'b0;
        rx_log.delete();
        start_send = 1'b1;
        tick();
        start_send = 1'b0;
        for (int k = 0; k < 9; k++) begin
            next_count = C'($urandom);
            tick();
        end
        start_send = 1'b1;
        tick();
        start_send = 1'b0;
        for (int k = 0; k < 6; k++) begin
            next_count = C'($urandom);
            tick();
        end
        next_count = '0;
        chk("stall_busy", busy, 1);
        chk("stall_level", fifo_level, 4);
        ready = 1'b1;
        wait_drain("bp_drain");
        chk("bp_words", rx_log.size(), 8);
        for (int k = 0; k < rx_log.size(); k++) chk("bp_order", rx_log[k][15:8], k % 4);

        // Coincident increment on ch1 during its capture.
        pulse_srst();
        rx_log.delete();
        start_send = 1'b1;
        tick();
        start_send = 1'b0;
        tick();
        next_count = 4'b0010;
        tick();
        next_count = '0;
        wait_drain("coin_drain1");
        start_send = 1'b1;
        tick();
        start_send = 1'b0;
        wait_drain("coin_drain2");
        chk("coin_words", rx_log.size(), 8);
        if (rx_log.size() == 8) begin
            chk("coin_first", rx_log[1], {8'd1, 8'd0});
            chk("coin_second", rx_log[5], {8'd1, 8'd1});
        end

        // Overflow: saturating main instance and wrapping second instance.
        pulse_srst();
        s_rst_w = 1'b1;
        tick();
        s_rst_w = 1'b0;
        ready_w = 1'b1;
        for (int k = 0; k < 300; k++) begin
            next_count = 4'b0100;
            nc_w       = 4'b0100;
            tick();
        end
        next_count = '0;
        nc_w = '0;
        chk("sat_ovf", overflow, 1);
        chk("wrap_ovf", overflow_w, 1);
        rx_log.delete();
        start_send = 1'b1;
        start_w    = 1'b1;
        tick();
        start_send = 1'b0;
        start_w    = 1'b0;
        got_w = '1;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (valid_w && chan_w == 2) got_w = data_w;
        end
        chk("wrap_value", got_w, 44);
        wait_drain("sat_drain");
        chk("sat_words", rx_log.size(), 4);
        if (rx_log.size() == 4) chk("sat_value", rx_log[2], {8'd2, 8'd255});
        pulse_srst();
        s_rst_w = 1'b1;
        tick();
        s_rst_w = 1'b0;
        chk("sat_ovf_clr", overflow, 0);
        chk("wrap_ovf_clr", overflow_w, 0);

        // Synchronous clear mid-dump with two words queued.
        ready = 1'b0;
        start_send = 1'b1;
        tick();
        start_send = 1'b0;
        tick();
        tick();
        chk("mid_level", fifo_level, 2);
        chk("mid_busy", busy, 1);
        s_rst = 1'b1;
        tick();
        s_rst = 1'b0;
        chk("srst_valid", valid, 0);
        chk("srst_busy", busy, 0);
        chk("srst_level", fifo_level, 0);

        // Asynchronous reset mid-transfer, checked before any clock edge.
        start_send = 1'b1;
        tick();
        start_send = 1'b0;
        repeat (3) tick();
        ready = 1'b1;
        tick();
        #1;
        a_rst_n = 1'b0;
        #1;
        chk("arst_valid", valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_level", fifo_level, 0);
        tick();
        a_rst_n = 1'b1;
        tick();

        // Random traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            next_count = C'($urandom);
            start_send = ($urandom % 8) == 0;
            ready      = ($urandom % 4) != 0;
            s_rst      = ($urandom % 200) == 0;
            tick();
        end
        next_count = '0;
        start_send = 1'b0;
        s_rst = 1'b0;
        ready = 1'b1;
        wait_drain("rand_drain");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/data_former_mc.md
Name: data_former_mc

Overview:
Multi-channel successor to the single-counter data former. It keeps one event counter per channel. On a start_send request it snapshots every channel counter in turn into an output FIFO, clearing each counter as it is captured. Words leave on a valid/ready stream with a channel tag. The block sits between event sources (next_count strobes) and the SPI transmit path, and adds buffering, lossless capture and overflow reporting.

Parameters:
p_data_width, 8, width of each counter and of data
p_channels, 4, number of counter channels (>=1)
p_depth, 4, FIFO depth in words (>=2)
p_saturate, 1, 1 = counters saturate at all-ones; 0 = counters wrap to 0

Ports:
clk  in  1  clock, rising edge
a_rst_n  in  1  asynchronous reset, active low
s_rst  in  1  synchronous clear, active high
next_count  in  p_channels  per-channel increment strobe, one increment per cycle high
start_send  in  1  snapshot request, sampled per cycle
ready  in  1  downstream ready
valid  out  1  FIFO head word valid
data  out  p_data_width  FIFO head count value
chan  out  $clog2(p_channels) (min 1)  channel index of head word
busy  out  1  snapshot in progress (state DUMP)
fifo_level  out  $clog2(p_depth+1)  words held
overflow  out  1  sticky: some counter hit its limit

Behaviour:
- Reset (a_rst_n=0, async) or s_rst=1 (sync, highest priority):
  - counters, FIFO, state and index cleared; state=IDLE.
  - valid=0, data=0, chan=0, busy=0, fifo_level=0, overflow=0.
- Counters:
  - cnt[i] increments when next_count[i]=1.
  - At all-ones plus an increment: p_saturate=1 holds all-ones; p_saturate=0 wraps to 0.
  - Either case sets overflow. overflow clears only on reset or s_rst.
- FSM states: IDLE, DUMP.
  - IDLE: start_send=1 -> DUMP, idx=0, busy=1 from the next cycle.
  - DUMP, each cycle with push allowed:
    - write {chan=idx, data=cnt[idx]} to the FIFO.
    - cnt[idx] is set to 1 if next_count[idx]=1 in the same cycle, else 0. No event is lost.
    - idx increments. After idx=p_channels-1 is pushed -> IDLE.
  - DUMP with push blocked: state and idx hold, counters keep counting normally.
  - start_send while in DUMP, or in the cycle DUMP returns to IDLE: ignored (not queued).
- Push allowed when fifo_level<p_depth, or fifo_level==p_depth with a pop in the same cycle.
- Latency: start_send sampled at edge T -> ch0 written at edge T+1 if space -> valid=1 after edge T+1.
  - An uninterrupted dump of N channels ends with busy=0 after edge T+N.
- Output stream:
  - pop occurs when valid&&ready.
  - data/chan are the FIFO head, held stable while valid&&!ready.
  - Order is strictly FIFO.
  - valid=0 when the FIFO is empty; data/chan are don't-care then but must not be X after reset.
- Simultaneous push and pop: fifo_level unchanged.
  - Empty FIFO with push: no bypass; valid rises the cycle after the write.
- fifo_level always reflects the post-edge occupancy, range 0..p_depth.

Test Plan:
- Reset: hold a_rst_n=0 with random inputs -> all outputs 0. Release, no stimulus -> outputs stay 0.
- Basic dump (defaults):
  - pulse next_count = 3,5,0,255 times on ch0..ch3, ready=1, then start_send.
  - expect words (0,3),(1,5),(2,0),(3,255); busy high exactly 4 cycles; counters read 0 afterwards.
- Backpressure:
  - ready=0, p_depth=4, p_channels=4, two start_sends 10 cycles apart.
  - second dump stalls with busy=1 and fifo_level=4; data stays stable.
  - raise ready -> all 8 words arrive in order, second set reflecting counts accrued during the stall.
- Coincident increment: next_count[1]=1 in the cycle ch1 is captured -> captured value excludes that event; next dump reports ch1=1.
- Overflow:
  - p_saturate=1: 300 strobes on ch2 -> value 255, overflow=1.
  - p_saturate=0: 300 strobes -> 44, overflow=1.
  - s_rst -> overflow=0.
- Mid-operation clears:
  - s_rst during DUMP with FIFO at 2 -> next cycle valid=0, busy=0, level=0.
  - a_rst_n low mid-transfer -> immediate clear without waiting for a clock.
